// File: rtl/dlx_pkg.sv
// Shared DLX pipeline definitions: widths, ALU op codes, forwarding selects.
package dlx_pkg;

  localparam int XLEN = 32;
  localparam int RIDX = 5;

  // ALU op codes, same encoding as the ALU Op port
  localparam logic [4:0] ALU_AND    = 5'b00000;
  localparam logic [4:0] ALU_OR     = 5'b00001;
  localparam logic [4:0] ALU_ADD    = 5'b00010;
  localparam logic [4:0] ALU_SUB    = 5'b00011;
  localparam logic [4:0] ALU_XOR    = 5'b00100;
  localparam logic [4:0] ALU_SLL    = 5'b00101;
  localparam logic [4:0] ALU_SRL    = 5'b00110;
  localparam logic [4:0] ALU_SLTU   = 5'b00111;
  localparam logic [4:0] ALU_SLT    = 5'b01000;
  localparam logic [4:0] ALU_SGE    = 5'b01001;
  localparam logic [4:0] ALU_ADDF   = 5'b01111;
  localparam logic [4:0] ALU_CVTITF = 5'b11110;
  localparam logic [4:0] ALU_CVTFTI = 5'b11111;

  // Op driven while EX holds a bubble; the add result is discarded downstream
  localparam logic [4:0] NOP_OP = ALU_ADD;

  typedef enum logic [1:0] {
    FWD_REG   = 2'd0,
    FWD_EXMEM = 2'd1,
    FWD_MEMWB = 2'd2
  } fwd_sel_t;

  // A forwarding source matches when it writes the same, non-zero register
  function automatic logic fwd_match(input logic               wr,
                                     input logic [RIDX-1:0]    src_rd,
                                     input logic [RIDX-1:0]    idx);
    return wr && (src_rd == idx) && (idx != '0);
  endfunction

endpackage

// File: rtl/fwd_mux.sv
// Per-operand forwarding: compares the stored register index against the
// EX/MEM and MEM/WB destinations and selects the newest value.
// Exposes o_fwd_hit only when ALU_OPERAND_STAGE_PERF_EN is defined.
import dlx_pkg::*;

module fwd_mux (
  input  logic [RIDX-1:0] i_idx,
  input  logic [XLEN-1:0] i_reg_val,
  input  logic [RIDX-1:0] i_exmem_rd,
  input  logic            i_exmem_wr,
  input  logic [XLEN-1:0] i_exmem_result,
  input  logic [RIDX-1:0] i_memwb_rd,
  input  logic            i_memwb_wr,
  input  logic [XLEN-1:0] i_memwb_result,
`ifdef ALU_OPERAND_STAGE_PERF_EN
  output logic            o_fwd_hit,
`endif
  output logic [XLEN-1:0] o_fwd_val
);

  fwd_sel_t w_sel;

  // EX/MEM is younger than MEM/WB, so it takes priority; R0 never forwards
  always_comb begin
    w_sel = FWD_REG;
    if (fwd_match(i_exmem_wr, i_exmem_rd, i_idx)) begin
      w_sel = FWD_EXMEM;
    end else if (fwd_match(i_memwb_wr, i_memwb_rd, i_idx)) begin
      w_sel = FWD_MEMWB;
    end
  end

  // 3:1 value mux driven by the select above
  always_comb begin
    o_fwd_val = i_reg_val;
    case (w_sel)
      FWD_EXMEM: o_fwd_val = i_exmem_result;
      FWD_MEMWB: o_fwd_val = i_memwb_result;
      default:   o_fwd_val = i_reg_val;
    endcase
  end

`ifdef ALU_OPERAND_STAGE_PERF_EN
  assign o_fwd_hit = (w_sel != FWD_REG);
`endif

endmodule

// File: rtl/alu_operand_stage.sv
// ID/EX stage in front of the DLX ALU: registers decoded operands, resolves
// forwarding, selects the immediate, raises load-use stalls, inserts bubbles.
// Optional performance counters: define ALU_OPERAND_STAGE_PERF_EN.
//
// Flow control: id_valid qualifies the decode-side fields. The stage takes
// the instruction on an edge only when mem_stall=0, flush=0 and id_stall=0;
// otherwise (id_stall or flush) a bubble enters EX and decode must hold its
// instruction while id_stall=1. mem_stall=1 freezes every register,
// including a pending flush, which upstream must keep asserted.
import dlx_pkg::*;

module alu_operand_stage (
  input  logic            clk,
  input  logic            rst,
  input  logic            id_valid,
  input  logic [XLEN-1:0] id_rs1_val,
  input  logic [XLEN-1:0] id_rs2_val,
  input  logic [XLEN-1:0] id_imm,
  input  logic            id_use_imm,
  input  logic [4:0]      id_alu_op,
  input  logic [RIDX-1:0] id_rs1_idx,
  input  logic [RIDX-1:0] id_rs2_idx,
  input  logic [RIDX-1:0] id_rd_idx,
  input  logic            id_reg_write,
  input  logic            id_is_load,
  input  logic            flush,
  input  logic            mem_stall,
  input  logic [RIDX-1:0] exmem_rd,
  input  logic            exmem_wr,
  input  logic [XLEN-1:0] exmem_result,
  input  logic [RIDX-1:0] memwb_rd,
  input  logic            memwb_wr,
  input  logic [XLEN-1:0] memwb_result,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [4:0]      alu_op,
  output logic            ex_valid,
  output logic [RIDX-1:0] ex_rd,
  output logic            ex_reg_write,
  output logic            ex_is_load,
  output logic [XLEN-1:0] ex_store_data,
`ifdef ALU_OPERAND_STAGE_PERF_EN
  output logic [31:0]     perf_issued,
  output logic [31:0]     perf_bubbles,
  output logic [31:0]     perf_fwd,
`endif
  output logic            id_stall
);

  // Stage registers
  logic            r_valid;
  logic            r_reg_write;
  logic            r_is_load;
  logic [RIDX-1:0] r_rd;
  logic [RIDX-1:0] r_rs1_idx;
  logic [RIDX-1:0] r_rs2_idx;
  logic [XLEN-1:0] r_rs1_val;
  logic [XLEN-1:0] r_rs2_val;
  logic [XLEN-1:0] r_imm;
  logic            r_use_imm;
  logic [4:0]      r_op;

  logic            w_id_stall;
  logic            w_capture;
  logic            w_bubble;
  logic [XLEN-1:0] w_rs1_fwd;
  logic [XLEN-1:0] w_rs2_fwd;

  // Load-use hazard: the load in EX cannot forward in time to the ID consumer
  always_comb begin
    w_id_stall = 1'b0;
    if (r_valid && r_is_load && (r_rd != '0) && id_valid) begin
      if ((r_rd == id_rs1_idx) || ((r_rd == id_rs2_idx) && !id_use_imm)) begin
        w_id_stall = 1'b1;
      end
    end
  end

  // Edge action: hold under mem_stall, else capture or bubble
  always_comb begin
    w_capture = !mem_stall && !flush && !w_id_stall && id_valid;
    w_bubble  = !mem_stall && !w_capture;
  end

  // Stage register update; bubbles leave operand fields at their old values
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid     <= 1'b0;
      r_reg_write <= 1'b0;
      r_is_load   <= 1'b0;
      r_rd        <= '0;
      r_rs1_idx   <= '0;
      r_rs2_idx   <= '0;
      r_rs1_val   <= '0;
      r_rs2_val   <= '0;
      r_imm       <= '0;
      r_use_imm   <= 1'b0;
      r_op        <= NOP_OP;
    end else if (w_capture) begin
      r_valid     <= 1'b1;
      r_reg_write <= id_reg_write;
      r_is_load   <= id_is_load;
      r_rd        <= id_rd_idx;
      r_rs1_idx   <= id_rs1_idx;
      r_rs2_idx   <= id_rs2_idx;
      r_rs1_val   <= id_rs1_val;
      r_rs2_val   <= id_rs2_val;
      r_imm       <= id_imm;
      r_use_imm   <= id_use_imm;
      r_op        <= id_alu_op;
    end else if (w_bubble) begin
      r_valid     <= 1'b0;
      r_reg_write <= 1'b0;
      r_is_load   <= 1'b0;
      r_op        <= NOP_OP;
    end
  end

`ifdef ALU_OPERAND_STAGE_PERF_EN
  logic w_rs1_hit;
  logic w_rs2_hit;
`endif

  fwd_mux u_fwd_rs1 (
    .i_idx          (r_rs1_idx),
    .i_reg_val      (r_rs1_val),
    .i_exmem_rd     (exmem_rd),
    .i_exmem_wr     (exmem_wr),
    .i_exmem_result (exmem_result),
    .i_memwb_rd     (memwb_rd),
    .i_memwb_wr     (memwb_wr),
    .i_memwb_result (memwb_result),
`ifdef ALU_OPERAND_STAGE_PERF_EN
    .o_fwd_hit      (w_rs1_hit),
`endif
    .o_fwd_val      (w_rs1_fwd)
  );

  fwd_mux u_fwd_rs2 (
    .i_idx          (r_rs2_idx),
    .i_reg_val      (r_rs2_val),
    .i_exmem_rd     (exmem_rd),
    .i_exmem_wr     (exmem_wr),
    .i_exmem_result (exmem_result),
    .i_memwb_rd     (memwb_rd),
    .i_memwb_wr     (memwb_wr),
    .i_memwb_result (memwb_result),
`ifdef ALU_OPERAND_STAGE_PERF_EN
    .o_fwd_hit      (w_rs2_hit),
`endif
    .o_fwd_val      (w_rs2_fwd)
  );

  // Output drive: B takes the immediate, stores always get forwarded rs2
  always_comb begin
    alu_a         = w_rs1_fwd;
    alu_b         = r_use_imm ? r_imm : w_rs2_fwd;
    alu_op        = r_op;
    ex_valid      = r_valid;
    ex_rd         = r_rd;
    ex_reg_write  = r_reg_write;
    ex_is_load    = r_is_load;
    ex_store_data = w_rs2_fwd;
    id_stall      = w_id_stall;
  end

`ifdef ALU_OPERAND_STAGE_PERF_EN
  logic [31:0] r_perf_issued;
  logic [31:0] r_perf_bubbles;
  logic [31:0] r_perf_fwd;
  logic        w_any_fwd;

  assign w_any_fwd = r_valid && (w_rs1_hit || w_rs2_hit);

  // Event counters, wrapping naturally at 2^32
  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf_issued  <= '0;
      r_perf_bubbles <= '0;
      r_perf_fwd     <= '0;
    end else begin
      if (w_capture) r_perf_issued  <= r_perf_issued + 32'd1;
      if (w_bubble)  r_perf_bubbles <= r_perf_bubbles + 32'd1;
      if (w_any_fwd) r_perf_fwd     <= r_perf_fwd + 32'd1;
    end
  end

  assign perf_issued  = r_perf_issued;
  assign perf_bubbles = r_perf_bubbles;
  assign perf_fwd     = r_perf_fwd;
`endif

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed bench for alu_operand_stage: reset, capture, forwarding priority,
// immediate select, load-use stall, flush, mem_stall hold, reset mid-stall.
// Counter checks run when ALU_OPERAND_STAGE_PERF_EN is defined.
module tb_alu_operand_stage;

  logic        clk;
  logic        rst;
  logic        id_valid;
  logic [31:0] id_rs1_val;
  logic [31:0] id_rs2_val;
  logic [31:0] id_imm;
  logic        id_use_imm;
  logic [4:0]  id_alu_op;
  logic [4:0]  id_rs1_idx;
  logic [4:0]  id_rs2_idx;
  logic [4:0]  id_rd_idx;
  logic        id_reg_write;
  logic        id_is_load;
  logic        flush;
  logic        mem_stall;
  logic [4:0]  exmem_rd;
  logic        exmem_wr;
  logic [31:0] exmem_result;
  logic [4:0]  memwb_rd;
  logic        memwb_wr;
  logic [31:0] memwb_result;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [4:0]  alu_op;
  logic        ex_valid;
  logic [4:0]  ex_rd;
  logic        ex_reg_write;
  logic        ex_is_load;
  logic [31:0] ex_store_data;
  logic        id_stall;
`ifdef ALU_OPERAND_STAGE_PERF_EN
  logic [31:0] perf_issued;
  logic [31:0] perf_bubbles;
  logic [31:0] perf_fwd;
`endif

  int checks;
  int failures;

  alu_operand_stage dut (
    .clk           (clk),
    .rst           (rst),
    .id_valid      (id_valid),
    .id_rs1_val    (id_rs1_val),
    .id_rs2_val    (id_rs2_val),
    .id_imm        (id_imm),
    .id_use_imm    (id_use_imm),
    .id_alu_op     (id_alu_op),
    .id_rs1_idx    (id_rs1_idx),
    .id_rs2_idx    (id_rs2_idx),
    .id_rd_idx     (id_rd_idx),
    .id_reg_write  (id_reg_write),
    .id_is_load    (id_is_load),
    .flush         (flush),
    .mem_stall     (mem_stall),
    .exmem_rd      (exmem_rd),
    .exmem_wr      (exmem_wr),
    .exmem_result  (exmem_result),
    .memwb_rd      (memwb_rd),
    .memwb_wr      (memwb_wr),
    .memwb_result  (memwb_result),
    .alu_a         (alu_a),
    .alu_b         (alu_b),
    .alu_op        (alu_op),
    .ex_valid      (ex_valid),
    .ex_rd         (ex_rd),
    .ex_reg_write  (ex_reg_write),
    .ex_is_load    (ex_is_load),
    .ex_store_data (ex_store_data),
`ifdef ALU_OPERAND_STAGE_PERF_EN
    .perf_issued   (perf_issued),
    .perf_bubbles  (perf_bubbles),
    .perf_fwd      (perf_fwd),
`endif
    .id_stall      (id_stall)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge and settle away from it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // All decode and forwarding inputs to an inert value
  task automatic set_idle();
    id_valid     = 1'b0;
    id_rs1_val   = '0;
    id_rs2_val   = '0;
    id_imm       = '0;
    id_use_imm   = 1'b0;
    id_alu_op    = 5'b00000;
    id_rs1_idx   = '0;
    id_rs2_idx   = '0;
    id_rd_idx    = '0;
    id_reg_write = 1'b0;
    id_is_load   = 1'b0;
    flush        = 1'b0;
    mem_stall    = 1'b0;
    exmem_rd     = '0;
    exmem_wr     = 1'b0;
    exmem_result = '0;
    memwb_rd     = '0;
    memwb_wr     = 1'b0;
    memwb_result = '0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    set_idle();
    rst = 1'b1;
    tick();

    // Reset state
    check("rst_ex_valid", {31'd0, ex_valid}, 32'd0);
    check("rst_alu_a", alu_a, 32'd0);
    check("rst_alu_b", alu_b, 32'd0);
    check("rst_alu_op", {27'd0, alu_op}, 32'h2);
    check("rst_id_stall", {31'd0, id_stall}, 32'd0);
    check("rst_reg_write", {31'd0, ex_reg_write}, 32'd0);
    check("rst_is_load", {31'd0, ex_is_load}, 32'd0);
    check("rst_ex_rd", {27'd0, ex_rd}, 32'd0);
    rst = 1'b0;

    // Plain capture of a SUB
    set_idle();
    id_valid = 1'b1; id_rs1_val = 32'd5; id_rs2_val = 32'd4; id_alu_op = 5'b00011;
    id_rs1_idx = 5'd1; id_rs2_idx = 5'd2; id_rd_idx = 5'd4; id_reg_write = 1'b1;
    tick();
    check("cap_alu_a", alu_a, 32'd5);
    check("cap_alu_b", alu_b, 32'd4);
    check("cap_alu_op", {27'd0, alu_op}, 32'h3);
    check("cap_ex_valid", {31'd0, ex_valid}, 32'd1);
    check("cap_ex_rd", {27'd0, ex_rd}, 32'd4);
    check("cap_reg_write", {31'd0, ex_reg_write}, 32'd1);
    check("cap_store_data", ex_store_data, 32'd4);

    // Forwarding priority on rs1=3, rs2=R0
    set_idle();
    id_valid = 1'b1; id_rs1_val = 32'h11; id_rs2_val = 32'h22; id_alu_op = 5'b00010;
    id_rs1_idx = 5'd3; id_rs2_idx = 5'd0; id_rd_idx = 5'd1;
    tick();
    id_valid = 1'b0;
    exmem_wr = 1'b1; exmem_rd = 5'd3; exmem_result = 32'h64;
    memwb_wr = 1'b1; memwb_rd = 5'd3; memwb_result = 32'h7;
    #1;
    check("fwd_exmem_wins", alu_a, 32'h64);
    exmem_wr = 1'b0;
    #1;
    check("fwd_memwb", alu_a, 32'h7);
    memwb_wr = 1'b0;
    #1;
    check("fwd_none", alu_a, 32'h11);
    exmem_wr = 1'b1; exmem_rd = 5'd0; exmem_result = 32'h99;
    #1;
    check("fwd_r0_b", alu_b, 32'h22);
    check("fwd_r0_a", alu_a, 32'h11);

    // Immediate on B while rs2 is forwardable
    set_idle();
    id_valid = 1'b1; id_use_imm = 1'b1; id_imm = 32'hFFFFFFEC; id_alu_op = 5'b00010;
    id_rs2_idx = 5'd6; id_rs2_val = 32'h33; id_rd_idx = 5'd2;
    tick();
    id_valid = 1'b0;
    memwb_wr = 1'b1; memwb_rd = 5'd6; memwb_result = 32'hABCD;
    #1;
    check("imm_alu_b", alu_b, 32'hFFFFFFEC);
    check("imm_store_fwd", ex_store_data, 32'hABCD);
    check("imm_alu_a", alu_a, 32'd0);

    // Load-use on rs1
    set_idle();
    id_valid = 1'b1; id_is_load = 1'b1; id_rd_idx = 5'd7; id_reg_write = 1'b1;
    id_use_imm = 1'b1; id_alu_op = 5'b00010;
    tick();
    check("ld_is_load", {31'd0, ex_is_load}, 32'd1);
    set_idle();
    id_valid = 1'b1; id_rs1_idx = 5'd7; id_rs1_val = 32'h10; id_rs2_val = 32'h20;
    id_alu_op = 5'b00011; id_rd_idx = 5'd8; id_reg_write = 1'b1;
    #1;
    check("lu_stall", {31'd0, id_stall}, 32'd1);
    tick();
    check("lu_bubble_valid", {31'd0, ex_valid}, 32'd0);
    check("lu_bubble_op", {27'd0, alu_op}, 32'h2);
    check("lu_bubble_wr", {31'd0, ex_reg_write}, 32'd0);
    check("lu_stall_clear", {31'd0, id_stall}, 32'd0);
    tick();
    check("lu_cap_valid", {31'd0, ex_valid}, 32'd1);
    check("lu_cap_op", {27'd0, alu_op}, 32'h3);
    check("lu_cap_a", alu_a, 32'h10);
    check("lu_cap_rd", {27'd0, ex_rd}, 32'd8);

    // Load-use on rs2 is masked by use_imm
    set_idle();
    id_valid = 1'b1; id_is_load = 1'b1; id_rd_idx = 5'd9; id_reg_write = 1'b1;
    id_use_imm = 1'b1;
    tick();
    set_idle();
    id_valid = 1'b1; id_rs2_idx = 5'd9; id_use_imm = 1'b1;
    #1;
    check("lu_rs2_imm", {31'd0, id_stall}, 32'd0);
    id_use_imm = 1'b0;
    #1;
    check("lu_rs2_reg", {31'd0, id_stall}, 32'd1);
    id_valid = 1'b0;
    #1;
    check("lu_no_id_valid", {31'd0, id_stall}, 32'd0);

    // Flush kills the captured instruction
    set_idle();
    id_valid = 1'b1; flush = 1'b1; id_alu_op = 5'b00100; id_reg_write = 1'b1;
    tick();
    check("flush_valid", {31'd0, ex_valid}, 32'd0);
    check("flush_op", {27'd0, alu_op}, 32'h2);

    // mem_stall holds everything for 3 edges, flush during stall is lost
    set_idle();
    id_valid = 1'b1; id_rs1_idx = 5'd1; id_rs1_val = 32'hA; id_rs2_idx = 5'd2;
    id_rs2_val = 32'hB; id_alu_op = 5'b00100; id_rd_idx = 5'd5; id_reg_write = 1'b1;
    tick();
    id_rs1_val = 32'hFFFF; id_rs2_val = 32'hEEEE; id_alu_op = 5'b00000; id_rd_idx = 5'd6;
    mem_stall = 1'b1;
    tick();
    flush = 1'b1;
    tick();
    tick();
    check("ms_alu_a", alu_a, 32'hA);
    check("ms_alu_b", alu_b, 32'hB);
    check("ms_alu_op", {27'd0, alu_op}, 32'h4);
    check("ms_valid", {31'd0, ex_valid}, 32'd1);
    check("ms_rd", {27'd0, ex_rd}, 32'd5);

    // Reset while stalled discards the held instruction
    rst = 1'b1;
    tick();
    check("rst_ms_valid", {31'd0, ex_valid}, 32'd0);
    check("rst_ms_op", {27'd0, alu_op}, 32'h2);
    check("rst_ms_a", alu_a, 32'd0);
    rst = 1'b0;
    set_idle();

`ifdef ALU_OPERAND_STAGE_PERF_EN
    // 4 captures, 2 bubbles, 1 forwarded cycle, then a held edge
    rst = 1'b1;
    tick();
    check("perf_rst_issued", perf_issued, 32'd0);
    check("perf_rst_bubbles", perf_bubbles, 32'd0);
    check("perf_rst_fwd", perf_fwd, 32'd0);
    rst = 1'b0;
    id_valid = 1'b1; id_rs1_idx = 5'd3;
    tick();
    id_rs1_idx = 5'd0;
    exmem_wr = 1'b1; exmem_rd = 5'd3; exmem_result = 32'h5;
    tick();
    exmem_wr = 1'b0;
    tick();
    tick();
    id_valid = 1'b0;
    tick();
    id_valid = 1'b1; flush = 1'b1;
    tick();
    id_valid = 1'b0; flush = 1'b0; mem_stall = 1'b1;
    tick();
    check("perf_issued", perf_issued, 32'd4);
    check("perf_bubbles", perf_bubbles, 32'd2);
    check("perf_fwd", perf_fwd, 32'd1);
    set_idle();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
